ghost_mode_fsm: RTL and testbench
=================================

Name: ghost_mode_fsm

Overview:
Per-ghost behaviour-mode controller that feeds one ghost pathing block (Blinky and siblings) with its one-hot `mode` and `rotate` inputs.
- Runs the scatter/chase wave schedule, the frightened timer and the eaten-return state.
- Converts game events (power pellet, ghost eaten, ghost reached house) into mode changes plus 180-degree reversal requests.
- Advances only on the game-step strobe `tick`, the same pulse that drives the ghost's `update`.

Parameters:
- TW, 12, width of all duration counters.
- SCAT_LONG, 420, ticks for scatter phases 0 and 2.
- SCAT_SHORT, 300, ticks for scatter phases 4 and 6.
- CHASE_LEN, 1200, ticks for chase phases 1, 3 and 5.
- FRIGHT_LEN, 360, ticks spent frightened per pellet.
- FLASH_LEN, 120, final frightened ticks during which `flashing` is high; must be less than or equal to FRIGHT_LEN.

Ports:
- clk, in, 1: system clock; all state changes on the rising edge.
- resetn, in, 1: synchronous, active-low reset.
- tick, in, 1: one-cycle game-step strobe; timers count only on cycles where it is high.
- level_start, in, 1: one-cycle pulse; restarts the schedule exactly as reset does.
- power_pellet, in, 1: one-cycle pulse; Pac-Man ate a power pellet.
- fright_enable, in, 1: level allows frightened mode (driven low from level 19 onward).
- ghost_eaten, in, 1: one-cycle pulse; Pac-Man touched this ghost.
- in_house, in, 1: level; ghost location equals the ghost-house target.
- mode, out, 4: one-hot mode. Chase=4'b1000, Scatter=4'b0100, Frightened=4'b0010, Eaten=4'b0001.
- rotate, out, 1: reversal request to the ghost pathing block.
- flashing, out, 1: frightened with the end of fright near; drives the sprite.
- phase, out, 3: current wave index 0..7.

Behaviour:
- Reset (resetn=0 at a clk edge) and level_start=1 both load the same state:
  - mode=Scatter, phase=0, schedule counter=SCAT_LONG, fright counter=0.
  - rotate=0, flashing=0.
- Wave schedule:
  - Phases 0..6 alternate S,C,S,C,S,C,S.
  - Durations in order: SCAT_LONG, CHASE_LEN, SCAT_LONG, CHASE_LEN, SCAT_SHORT, CHASE_LEN, SCAT_SHORT.
  - Phase 7 is Chase and lasts forever; its counter holds.
- Base mode = Scatter for even phase, Chase for odd phase.
- Schedule counter:
  - Decrements on tick in Scatter, Chase and Eaten states.
  - Is frozen while Frightened.
  - A tick arriving with the counter at 1 advances the phase and loads the next duration in the same edge. Each phase therefore lasts exactly its duration in ticks.
- State machine: states SCHED (mode = base mode), FRIGHT, EATEN.
  - SCHED, phase advance: mode follows the new base mode; reversal requested.
  - SCHED, power_pellet with fright_enable=1: go to FRIGHT, load fright counter=FRIGHT_LEN, request reversal.
  - SCHED, power_pellet with fright_enable=0: stay in SCHED; reversal only.
  - FRIGHT, power_pellet: reload FRIGHT_LEN; no new reversal request.
  - FRIGHT, ghost_eaten: go to EATEN; fright counter cleared.
  - FRIGHT, tick with fright counter=1: go to SCHED at the current base mode; no reversal.
  - EATEN: power_pellet ignored. A phase advance updates the base mode silently, with no reversal.
  - EATEN with in_house=1: go to SCHED; no reversal.
  - ghost_eaten outside FRIGHT: ignored.
- Same-edge priority, highest first: resetn, level_start, ghost_eaten, power_pellet, in_house, tick expiry.
  - A pellet on a tick cycle wins; neither counter decrements that edge.
  - A phase expiry on the same edge as a pellet is deferred, because the schedule counter is already frozen.
- rotate:
  - Set the edge after a reversal request.
  - Held high through the next tick cycle so the pathing block samples it on its update edge.
  - Cleared on the edge following that tick.
  - A new request while high keeps it high and does not stack.
- flashing = (state==FRIGHT) and (fright counter <= FLASH_LEN). Registered, and updated on the same edge as the counter.
- Outputs are registered; latency from an event pulse to mode/rotate is one clk.
- Counters never underflow: the expiry check happens before decrement, and a counter at 0 holds.

Test Plan:
Test parameters for all scenarios: SCAT_LONG=4, CHASE_LEN=6, SCAT_SHORT=3, FRIGHT_LEN=5, FLASH_LEN=2.
1. Reset, then 32 ticks spaced 3 clks apart:
   - mode goes 0100 → 1000 after tick 4, → 0100 after tick 10, → 1000 after tick 14, and so on.
   - phase=7 and mode=1000 after tick 32; unchanged after a further 100 ticks.
   - rotate is high for exactly one tick window after each of the 7 changes.
2. power_pellet at phase 1 with 2 ticks elapsed:
   - mode=0010 next clk and rotate=1.
   - flashing rises after tick 3 of fright (counter=2).
   - After 5 ticks, mode=1000 with rotate=0; the chase phase then finishes after 4 more ticks.
3. Fright, then ghost_eaten:
   - mode=0001, flashing=0.
   - power_pellet is ignored.
   - in_house=1 gives mode equal to the base mode and no rotate.
4. power_pellet with fright_enable=0: mode unchanged, rotate=1 for one tick window.
5. Same-cycle events:
   - power_pellet together with a tick at schedule count 1 gives Frightened, with the phase unchanged.
   - ghost_eaten together with power_pellet in FRIGHT gives Eaten.
6. Reset and level_start mid-operation:
   - resetn=0 or level_start while Eaten in phase 3 gives mode=0100, phase=0, rotate=0, flashing=0 on the next edge.

Source files
------------

// File: rtl/ghost_mode_fsm.sv
// Per-ghost behaviour-mode controller: scatter/chase wave schedule, frightened timer
// and eaten-return state, producing one-hot mode plus reversal requests for pathing.
module ghost_mode_fsm #(
  parameter int TW         = 12,
  parameter int SCAT_LONG  = 420,
  parameter int SCAT_SHORT = 300,
  parameter int CHASE_LEN  = 1200,
  parameter int FRIGHT_LEN = 360,
  parameter int FLASH_LEN  = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic       level_start,
  input  logic       power_pellet,
  input  logic       fright_enable,
  input  logic       ghost_eaten,
  input  logic       in_house,
  output logic [3:0] mode,
  output logic       rotate,
  output logic       flashing,
  output logic [2:0] phase
);

  localparam logic [1:0] ST_SCHED  = 2'd0;
  localparam logic [1:0] ST_FRIGHT = 2'd1;
  localparam logic [1:0] ST_EATEN  = 2'd2;

  localparam logic [3:0] M_CHASE  = 4'b1000;
  localparam logic [3:0] M_SCAT   = 4'b0100;
  localparam logic [3:0] M_FRIGHT = 4'b0010;
  localparam logic [3:0] M_EATEN  = 4'b0001;

  localparam logic [TW-1:0] CNT_ZERO = TW'(0);
  localparam logic [TW-1:0] CNT_ONE  = TW'(1);
  localparam logic [TW-1:0] SL_C     = TW'(SCAT_LONG);
  localparam logic [TW-1:0] SS_C     = TW'(SCAT_SHORT);
  localparam logic [TW-1:0] CH_C     = TW'(CHASE_LEN);
  localparam logic [TW-1:0] FR_C     = TW'(FRIGHT_LEN);
  localparam logic [TW-1:0] FL_C     = TW'(FLASH_LEN);

  logic [1:0]    state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic [TW-1:0] sched_cnt_q, sched_cnt_d;
  logic [TW-1:0] fright_cnt_q, fright_cnt_d;
  logic [3:0]    mode_q, mode_d;
  logic          rotate_q, rotate_d;
  logic          flashing_q, flashing_d;
  logic          sched_run_s;
  logic          advance_s;
  logic          rev_req_s;

  // Phase 7 loads zero so its counter simply holds forever.
  function automatic logic [TW-1:0] phase_dur(input logic [2:0] p);
    case (p)
      3'd0, 3'd2:       phase_dur = SL_C;
      3'd1, 3'd3, 3'd5: phase_dur = CH_C;
      3'd4, 3'd6:       phase_dur = SS_C;
      default:          phase_dur = CNT_ZERO;
    endcase
  endfunction

  function automatic logic [3:0] base_mode(input logic [2:0] p);
    base_mode = p[0] ? M_CHASE : M_SCAT;
  endfunction

  // Next-state: event priority, both counters, reversal requests and registered outputs.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    sched_cnt_d  = sched_cnt_q;
    fright_cnt_d = fright_cnt_q;
    sched_run_s  = 1'b0;
    advance_s    = 1'b0;
    rev_req_s    = 1'b0;
    if (level_start) begin
      state_d      = ST_SCHED;
      phase_d      = 3'd0;
      sched_cnt_d  = SL_C;
      fright_cnt_d = CNT_ZERO;
    end else begin
      case (state_q)
        ST_SCHED: begin
          if (power_pellet) begin
            rev_req_s = 1'b1;
            if (fright_enable) begin
              state_d      = ST_FRIGHT;
              fright_cnt_d = FR_C;
            end else begin
              state_d = ST_SCHED;
            end
          end else begin
            sched_run_s = tick;
          end
        end
        ST_FRIGHT: begin
          if (ghost_eaten) begin
            state_d      = ST_EATEN;
            fright_cnt_d = CNT_ZERO;
          end else if (power_pellet) begin
            fright_cnt_d = FR_C;
          end else if (tick) begin
            if (fright_cnt_q == CNT_ONE) begin
              state_d      = ST_SCHED;
              fright_cnt_d = CNT_ZERO;
            end else if (fright_cnt_q != CNT_ZERO) begin
              fright_cnt_d = fright_cnt_q - CNT_ONE;
            end else begin
              fright_cnt_d = fright_cnt_q;
            end
          end else begin
            fright_cnt_d = fright_cnt_q;
          end
        end
        ST_EATEN: begin
          sched_run_s = tick;
          if (in_house) begin
            state_d = ST_SCHED;
          end else begin
            state_d = ST_EATEN;
          end
        end
        default: begin
          state_d      = ST_SCHED;
          fright_cnt_d = CNT_ZERO;
        end
      endcase

      if (sched_run_s) begin
        if (sched_cnt_q == CNT_ONE) begin
          advance_s   = 1'b1;
          phase_d     = phase_q + 3'd1;
          sched_cnt_d = phase_dur(phase_q + 3'd1);
        end else if (sched_cnt_q != CNT_ZERO) begin
          sched_cnt_d = sched_cnt_q - CNT_ONE;
        end else begin
          sched_cnt_d = sched_cnt_q;
        end
      end else begin
        sched_cnt_d = sched_cnt_d;
      end

      // Phase changes while eaten are silent.
      if (advance_s && (state_q == ST_SCHED)) begin
        rev_req_s = 1'b1;
      end else begin
        rev_req_s = rev_req_s;
      end
    end

    case (state_d)
      ST_FRIGHT: mode_d = M_FRIGHT;
      ST_EATEN:  mode_d = M_EATEN;
      default:   mode_d = base_mode(phase_d);
    endcase

    if (level_start) begin
      rotate_d = 1'b0;
    end else if (rev_req_s) begin
      rotate_d = 1'b1;
    end else if (tick) begin
      rotate_d = 1'b0;
    end else begin
      rotate_d = rotate_q;
    end

    flashing_d = (state_d == ST_FRIGHT) && (fright_cnt_d <= FL_C);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_SCHED;
      phase_q      <= 3'd0;
      sched_cnt_q  <= SL_C;
      fright_cnt_q <= CNT_ZERO;
      mode_q       <= M_SCAT;
      rotate_q     <= 1'b0;
      flashing_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      sched_cnt_q  <= sched_cnt_d;
      fright_cnt_q <= fright_cnt_d;
      mode_q       <= mode_d;
      rotate_q     <= rotate_d;
      flashing_q   <= flashing_d;
    end
  end

  assign mode     = mode_q;
  assign rotate   = rotate_q;
  assign flashing = flashing_q;
  assign phase    = phase_q;

endmodule

// File: tb/tb_ghost_mode_fsm.sv
// Directed bench for ghost_mode_fsm: an elapsed-tick schedule model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_ghost_mode_fsm;
  localparam int SL = 4, CL = 6, SS = 3, FL = 5, FLASH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, tick, level_start, power_pellet, fright_enable, ghost_eaten, in_house;
  logic [3:0] mode;
  logic rotate, flashing;
  logic [2:0] phase;

  ghost_mode_fsm #(.TW(12), .SCAT_LONG(SL), .SCAT_SHORT(SS), .CHASE_LEN(CL),
                   .FRIGHT_LEN(FL), .FLASH_LEN(FLASH)) dut (
    .clk(clk), .resetn(resetn), .tick(tick), .level_start(level_start),
    .power_pellet(power_pellet), .fright_enable(fright_enable),
    .ghost_eaten(ghost_eaten), .in_house(in_house),
    .mode(mode), .rotate(rotate), .flashing(flashing), .phase(phase)
  );

  int vectors = 0, miscompares = 0;
  int dur [7] = '{SL, CL, SL, CL, SS, CL, SS};

  // Model: schedule as total ticks elapsed; state 0=schedule, 1=frightened, 2=eaten.
  int m_elapsed = 0, m_state = 0, m_fright = 0;
  bit m_rot = 1'b0, m_valid = 1'b0;
  int rot_rises = 0;
  bit rot_prev = 1'b0;

  function automatic int phase_of(input int e);
    int acc = 0;
    int p = 0;
    for (int k = 0; k < 7; k++) begin
      acc += dur[k];
      if (e >= acc) p = k + 1;
    end
    return p;
  endfunction

  function automatic logic [3:0] exp_mode();
    if (m_state == 1) return 4'b0010;
    if (m_state == 2) return 4'b0001;
    return (phase_of(m_elapsed) % 2 == 1) ? 4'b1000 : 4'b0100;
  endfunction

  function automatic void model_step();
    bit req = 1'b0;
    bit run = tick;
    int st0 = m_state;
    int old_ph;
    if (!resetn || level_start) begin
      m_elapsed = 0; m_state = 0; m_fright = 0; m_rot = 1'b0; m_valid = 1'b1;
      return;
    end
    case (m_state)
      0: if (power_pellet) begin
           req = 1'b1; run = 1'b0;
           if (fright_enable) begin m_state = 1; m_fright = FL; end
         end
      1: begin
           run = 1'b0;
           if (ghost_eaten) begin m_state = 2; m_fright = 0; end
           else if (power_pellet) m_fright = FL;
           else if (tick) begin
             m_fright--;
             if (m_fright == 0) m_state = 0;
           end
         end
      default: if (in_house) m_state = 0;
    endcase
    if (run) begin
      old_ph = phase_of(m_elapsed);
      m_elapsed++;
      if (phase_of(m_elapsed) != old_ph && st0 == 0) req = 1'b1;
    end
    if (req) m_rot = 1'b1;
    else if (tick) m_rot = 1'b0;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances on the same edge as the DUT.
  task automatic cyc(input bit t, input bit pp, input bit ge, input bit ih, input bit ls, input bit rn);
    tick = t; power_pellet = pp; ghost_eaten = ge; in_house = ih; level_start = ls; resetn = rn;
    @(posedge clk);
    model_step();
    @(negedge clk);
    tick = 0; power_pellet = 0; ghost_eaten = 0; in_house = 0; level_start = 0; resetn = 1;
  endtask

  task automatic idle();     cyc(0, 0, 0, 0, 0, 1); endtask
  task automatic do_tick();  cyc(1, 0, 0, 0, 0, 1); idle(); idle(); endtask
  task automatic pellet();   cyc(0, 1, 0, 0, 0, 1); endtask
  task automatic eaten();    cyc(0, 0, 1, 0, 0, 1); endtask
  task automatic house();    cyc(0, 0, 0, 1, 0, 1); endtask
  task automatic do_reset(); cyc(0, 0, 0, 0, 0, 0); endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_mode"}, mode, 4'b0100);
    chk({tag, "_phase"}, {1'b0, phase}, 4'd0);
    chk({tag, "_rotate"}, {3'b0, rotate}, 4'd0);
    chk({tag, "_flash"}, {3'b0, flashing}, 4'd0);
  endtask

  // Compare process: every cycle after the first reset edge.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("cyc_mode", mode, exp_mode());
      chk("cyc_phase", {1'b0, phase}, 4'(phase_of(m_elapsed)));
      chk("cyc_rotate", {3'b0, rotate}, {3'b0, m_rot});
      chk("cyc_flash", {3'b0, flashing}, {3'b0, (m_state == 1 && m_fright <= FLASH)});
      if (rotate === 1'b1 && !rot_prev) rot_rises++;
      rot_prev = (rotate === 1'b1);
    end
  end

  initial begin
    int r0;
    resetn = 0; tick = 0; level_start = 0; power_pellet = 0;
    fright_enable = 1; ghost_eaten = 0; in_house = 0;
    @(negedge clk);
    do_reset(); do_reset();
    chk_idle_outs("rst");

    // Full wave schedule.
    r0 = rot_rises;
    for (int i = 1; i <= 32; i++) begin
      do_tick();
      if (i == 3)  chk("t1_s0_mode", mode, 4'b0100);
      if (i == 4)  begin chk("t1_c1_mode", mode, 4'b1000); chk("t1_c1_rot", {3'b0, rotate}, 4'd1); end
      if (i == 5)  chk("t1_rot_clear", {3'b0, rotate}, 4'd0);
      if (i == 10) begin chk("t1_s2_mode", mode, 4'b0100); chk("t1_s2_phase", {1'b0, phase}, 4'd2); end
      if (i == 14) begin chk("t1_c3_mode", mode, 4'b1000); chk("t1_c3_phase", {1'b0, phase}, 4'd3); end
    end
    chk("t1_p7_phase", {1'b0, phase}, 4'd7);
    chk("t1_p7_mode", mode, 4'b1000);
    chk("t1_rises", 4'(rot_rises - r0), 4'd7);
    for (int i = 0; i < 100; i++) do_tick();
    chk("t1_hold_phase", {1'b0, phase}, 4'd7);
    chk("t1_hold_mode", mode, 4'b1000);
    chk("t1_hold_rises", 4'(rot_rises - r0), 4'd7);

    // Fright in chase phase 1 with 2 ticks elapsed.
    do_reset();
    for (int i = 0; i < 6; i++) do_tick();
    chk("t2_phase", {1'b0, phase}, 4'd1);
    pellet();
    chk("t2_fr_mode", mode, 4'b0010);
    chk("t2_fr_rot", {3'b0, rotate}, 4'd1);
    for (int i = 1; i <= 5; i++) begin
      do_tick();
      if (i == 2) chk("t2_noflash", {3'b0, flashing}, 4'd0);
      if (i == 3) chk("t2_flash", {3'b0, flashing}, 4'd1);
    end
    chk("t2_back_mode", mode, 4'b1000);
    chk("t2_back_rot", {3'b0, rotate}, 4'd0);
    for (int i = 0; i < 3; i++) do_tick();
    chk("t2_still_p1", {1'b0, phase}, 4'd1);
    do_tick();
    chk("t2_p2", {1'b0, phase}, 4'd2);
    chk("t2_p2_mode", mode, 4'b0100);

    // Eaten: pellet ignored, silent phase advance, return home.
    pellet();
    eaten();
    chk("t3_eaten", mode, 4'b0001);
    chk("t3_flash", {3'b0, flashing}, 4'd0);
    pellet();
    chk("t3_pp_ign", mode, 4'b0001);
    for (int i = 0; i < 4; i++) do_tick();
    chk("t3_p3", {1'b0, phase}, 4'd3);
    chk("t3_silent", {3'b0, rotate}, 4'd0);
    house();
    chk("t3_home_mode", mode, 4'b1000);
    chk("t3_home_rot", {3'b0, rotate}, 4'd0);

    // level_start while eaten in phase 3.
    pellet();
    eaten();
    cyc(0, 0, 0, 0, 1, 1);
    chk_idle_outs("ls");

    // Pellet with fright disabled: reversal only.
    fright_enable = 0;
    pellet();
    chk("t4_mode", mode, 4'b0100);
    chk("t4_rot", {3'b0, rotate}, 4'd1);
    do_tick();
    chk("t4_rot_clr", {3'b0, rotate}, 4'd0);
    fright_enable = 1;

    // Same-cycle events.
    do_tick(); do_tick();
    cyc(1, 1, 0, 0, 0, 1);
    chk("t5_fr", mode, 4'b0010);
    chk("t5_phase", {1'b0, phase}, 4'd0);
    cyc(0, 1, 1, 0, 0, 1);
    chk("t5_eat", mode, 4'b0001);
    house();
    do_tick();
    chk("t5_deferred", {1'b0, phase}, 4'd1);

    // Reset while eaten in phase 3.
    for (int i = 0; i < 10; i++) do_tick();
    pellet();
    eaten();
    chk("t6_pre", mode, 4'b0001);
    do_reset();
    chk_idle_outs("t6_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
